ula_result_buffer: RTL and testbench

- Downstream stage of the ula: captures every result the ula flags with o_data_valid, together with its carry-out and the op code that produced it.
- Holds results in a DEPTH-entry first-in first-out buffer and presents them to the consumer on a valid/ready handshake.
- The ula has no backpressure input, so when the buffer is full, incoming results are dropped and counted through a sticky overflow flag.

---
 rtl/ula_result_buffer.sv | 197 +++++++++++++++++++
 tb/tb_ula_result_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_result_buffer.sv
// ---------------------------------------------------------------------------
// ula_result_buffer
//
// Captures every result the ula flags with i_data_valid (result word,
// carry-out and the producing op code) into a DEPTH-entry FIFO and presents
// the head entry to a consumer on a valid/ready handshake with first-word
// fall-through. The ula cannot be stalled, so a result arriving while the
// buffer is full (and nothing is popped that cycle) is dropped and recorded
// in the sticky o_overflow flag.
//
// Optional build macro: ULA_RB_STATS_EN
//   When defined, adds saturating 16-bit counters of accepted pushes
//   (o_push_cnt) and dropped results (o_drop_cnt), cleared by i_clear_ovf.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous reset, active low
//   i_data_valid     ula result strobe (one push attempt per high cycle)
//   i_data_result    ula result word
//   i_data_carryout  ula carry-out
//   i_op_selector    op code tag stored with the result
//   i_out_ready      consumer accepts the head entry
//   i_clear_ovf      clears o_overflow (and the stats counters if present)
//   o_out_valid      head entry available
//   o_out_result     head entry result (0 while empty)
//   o_out_carryout   head entry carry-out (0 while empty)
//   o_out_op         head entry op tag (0 while empty)
//   o_count          occupied entries, 0..DEPTH
//   o_full           o_count == DEPTH
//   o_empty          o_count == 0
//   o_overflow       sticky: at least one result was dropped
//   o_push_cnt       accepted pushes      (ULA_RB_STATS_EN only)
//   o_drop_cnt       dropped results      (ULA_RB_STATS_EN only)
// ---------------------------------------------------------------------------
module ula_result_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_data_valid,
  input  logic [31:0]      i_data_result,
  input  logic             i_data_carryout,
  input  logic [4:0]       i_op_selector,
  input  logic             i_out_ready,
  input  logic             i_clear_ovf,
  output logic             o_out_valid,
  output logic [31:0]      o_out_result,
  output logic             o_out_carryout,
  output logic [4:0]       o_out_op,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
`ifdef ULA_RB_STATS_EN
  ,
  output logic [15:0]      o_push_cnt,
  output logic [15:0]      o_drop_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Entry layout {op, carryout, result}: 38 bits, stored unmodified.
  typedef struct packed {
    logic [4:0]  op;
    logic        carry;
    logic [31:0] result;
  } entry_t;

  entry_t             mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               ovf_q,    ovf_d;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               drop;
  entry_t             wr_entry;
  entry_t             head;

  // -------------------------------------------------------------------------
  // Status and handshake decode
  // -------------------------------------------------------------------------
  // Full/empty come from the occupancy count, so equal pointers are never
  // ambiguous across the DEPTH-1 -> 0 wrap.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign pop   = !empty && i_out_ready;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push  = i_data_valid && (!full || pop);
  assign drop  = i_data_valid && !push;

  assign wr_entry = '{op: i_op_selector, carry: i_data_carryout, result: i_data_result};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)             ovf_d = 1'b1;
    else if (i_clear_ovf) ovf_d = 1'b0;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // -------------------------------------------------------------------------
  // Head outputs (first-word fall-through, zeroed while empty)
  // -------------------------------------------------------------------------
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (empty) head = '0;
  end

  assign o_out_valid    = !empty;
  assign o_out_result   = head.result;
  assign o_out_carryout = head.carry;
  assign o_out_op       = head.op;
  assign o_count        = count_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_overflow     = ovf_q;

`ifdef ULA_RB_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating push/drop statistics
  // -------------------------------------------------------------------------
  logic [15:0] push_cnt_q, push_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // A clear coinciding with an increment leaves the counter at 1.
  always_comb begin
    push_cnt_d = push_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (i_clear_ovf)               push_cnt_d = {15'd0, push};
    else if (push && push_cnt_q != '1) push_cnt_d = push_cnt_q + 16'd1;

    if (i_clear_ovf)               drop_cnt_d = {15'd0, drop};
    else if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_push_cnt = push_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ula_result_buffer.sv
module tb_ula_result_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_data_valid = 1'b0;
  logic [31:0]      i_data_result = '0;
  logic             i_data_carryout = 1'b0;
  logic [4:0]       i_op_selector = '0;
  logic             i_out_ready = 1'b0;
  logic             i_clear_ovf = 1'b0;
  logic             o_out_valid;
  logic [31:0]      o_out_result;
  logic             o_out_carryout;
  logic [4:0]       o_out_op;
  logic [CNT_W-1:0] o_count;
  logic             o_full;
  logic             o_empty;
  logic             o_overflow;
`ifdef ULA_RB_STATS_EN
  logic [15:0]      o_push_cnt;
  logic [15:0]      o_drop_cnt;
`endif

  ula_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_data_valid    (i_data_valid),
    .i_data_result   (i_data_result),
    .i_data_carryout (i_data_carryout),
    .i_op_selector   (i_op_selector),
    .i_out_ready     (i_out_ready),
    .i_clear_ovf     (i_clear_ovf),
    .o_out_valid     (o_out_valid),
    .o_out_result    (o_out_result),
    .o_out_carryout  (o_out_carryout),
    .o_out_op        (o_out_op),
    .o_count         (o_count),
    .o_full          (o_full),
    .o_empty         (o_empty),
    .o_overflow      (o_overflow)
`ifdef ULA_RB_STATS_EN
    ,
    .o_push_cnt      (o_push_cnt),
    .o_drop_cnt      (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic [4:0]  op;
  } ent_t;

  typedef struct {
    logic        v;
    logic [31:0] r;
    logic        c;
    logic [4:0]  op;
    logic        rdy;
    logic        clr;
    int unsigned exp_count;
    logic        exp_full;
    logic        exp_ovf;
  } vec_t;

  ent_t sb[$];
  logic exp_ovf = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl [12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the head against the scoreboard
  // before the edge, update the model, then check state after the edge.
  task automatic cycle(input logic v, input logic [31:0] r, input logic c,
                       input logic [4:0] op, input logic rdy, input logic clr);
    bit   m_pop, m_push, m_full;
    ent_t e;
    i_data_valid    = v;
    i_data_result   = r;
    i_data_carryout = c;
    i_op_selector   = op;
    i_out_ready     = rdy;
    i_clear_ovf     = clr;
    #1;
    check("valid_vs_model", 64'(o_out_valid), 64'(sb.size() != 0));
    if (sb.size() == 0)
      check("empty_head_zero", {26'd0, o_out_op, o_out_carryout, o_out_result}, 64'd0);
    m_full = (sb.size() == DEPTH);
    m_pop  = rdy && (sb.size() != 0);
    m_push = v && (!m_full || m_pop);
    if (m_pop) begin
      e = sb.pop_front();
      check("pop_result", 64'(o_out_result), 64'(e.r));
      check("pop_carry",  64'(o_out_carryout), 64'(e.c));
      check("pop_op",     64'(o_out_op), 64'(e.op));
    end
    if (m_push) sb.push_back('{r: r, c: c, op: op});
    if (v && !m_push) exp_ovf = 1'b1;
    else if (clr)     exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("count_vs_model", 64'(o_count), 64'(sb.size()));
    check("ovf_vs_model",   64'(o_overflow), 64'(exp_ovf));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_data_valid = 1'b0;
    i_out_ready  = 1'b0;
    i_clear_ovf  = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill/overflow table: 8 fills, a dropped 9th, clear, clear+drop, clear.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{v: 1'b1, r: 32'h100 + 32'(i), c: 1'(i), op: 5'(i + 4), rdy: 1'b0,
                 clr: 1'b0, exp_count: i + 1, exp_full: (i == 7), exp_ovf: 1'b0};
    tbl[8]  = '{1'b1, 32'hFA, 1'b1, OP_ADD, 1'b0, 1'b0, 8, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,  1'b0, OP_ADD, 1'b0, 1'b1, 8, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 32'hFB, 1'b0, OP_SUB, 1'b0, 1'b1, 8, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 32'h0,  1'b0, OP_ADD, 1'b0, 1'b1, 8, 1'b1, 1'b0};

    // Reset then idle
    do_reset();
    check("rst_empty",    64'(o_empty), 64'd1);
    check("rst_valid",    64'(o_out_valid), 64'd0);
    check("rst_full",     64'(o_full), 64'd0);
    check("rst_count",    64'(o_count), 64'd0);
    check("rst_overflow", 64'(o_overflow), 64'd0);
    check("rst_result",   64'(o_out_result), 64'd0);

    // Single push, visible next cycle
    cycle(1'b1, 32'h00001000, 1'b0, OP_ADD, 1'b0, 1'b0);
    check("single_valid",  64'(o_out_valid), 64'd1);
    check("single_result", 64'(o_out_result), 64'h1000);
    check("single_op",     64'(o_out_op), 64'(OP_ADD));
    check("single_count",  64'(o_count), 64'd1);

    // Ordering
    cycle(1'b1, 32'h3, 1'b1, OP_SUB, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, 1'b0, OP_MUL, 1'b0, 1'b0);
    cycle(1'b1, 32'h2, 1'b1, OP_DIV, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0);
    check("order_empty", 64'(o_empty), 64'd1);
    // Ready while empty: nothing changes
    cycle(1'b0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0);
    check("empty_ready_count", 64'(o_count), 64'd0);

    // Fill, overflow, clear (pointers start at 4, so the fill wraps)
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].op, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d_count", i), 64'(o_count), 64'(tbl[i].exp_count));
      check($sformatf("tbl%0d_full", i),  64'(o_full), 64'(tbl[i].exp_full));
      check($sformatf("tbl%0d_ovf", i),   64'(o_overflow), 64'(tbl[i].exp_ovf));
    end
    check("full_head", 64'(o_out_result), 64'h100);

    // Full with simultaneous push and pop
    cycle(1'b1, 32'hAB, 1'b1, 5'd31, 1'b1, 1'b0);
    check("fullpp_count", 64'(o_count), 64'd8);
    check("fullpp_ovf",   64'(o_overflow), 64'd0);
    check("fullpp_full",  64'(o_full), 64'd1);
    // Drain: scoreboard verifies 0x101..0x107 then 0xAB last
    repeat (7) cycle(1'b0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0);
    check("last_entry", 64'(o_out_result), 64'hAB);
    check("last_op",    64'(o_out_op), 64'd31);
    cycle(1'b0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0);
    check("drain_empty", 64'(o_empty), 64'd1);

    // Asynchronous reset mid-stream with 3 entries held
    cycle(1'b1, 32'h11, 1'b0, OP_ADD, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, OP_SUB, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, OP_MUL, 1'b0, 1'b0);
    check("held3_count", 64'(o_count), 64'd3);
    i_data_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("async_rst_count", 64'(o_count), 64'd0);
    check("async_rst_valid", 64'(o_out_valid), 64'd0);
    sb.delete();
    exp_ovf = 1'b0;
    #1;
    rst = 1'b1;
    cycle(1'b1, 32'h44, 1'b1, OP_DIV, 1'b0, 1'b0);
    check("post_rst_head", 64'(o_out_result), 64'h44);
    cycle(1'b0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0);

`ifdef ULA_RB_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h200 + 32'(i), 1'b0, OP_ADD, 1'b0, 1'b0);
    check("stats_push", 64'(o_push_cnt), 64'd8);
    check("stats_drop", 64'(o_drop_cnt), 64'd2);
    // Clear coinciding with a drop leaves drop count at 1
    cycle(1'b1, 32'h300, 1'b0, OP_ADD, 1'b0, 1'b1);
    check("stats_clr_push", 64'(o_push_cnt), 64'd0);
    check("stats_clr_drop", 64'(o_drop_cnt), 64'd1);
    repeat (8) cycle(1'b0, 32'h0, 1'b0, OP_ADD, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
